mem_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared single-port memory command bus (6-bit `addr`, 1-bit `en`, 1-bit `wr`, write data), clocked by the 25 MHz system clock. It grants the bus to one requester at a time, with bounded bursts. It registers the winning requester's beats onto the bus one cycle after acceptance. It replaces direct per-agent driving of `en`/`wr`/`addr`.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_pick.sv | 17 +
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : bus ownership state (IDLE, OWN0, OWN1)
//   mem_cmd_t   : one memory beat {wr, addr, wdata}; used for requester
//                 muxing and for the registered bus command.
// The mem_cmd_t field widths are taken from the DEF_* values below, so a
// design instance that overrides ADDR_W/DATA_W needs these updated too.
package mem_arb_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational two-way round-robin select.
//   req0, req1 : candidate requests
//   last       : most recent owner (0 or 1)
//   valid      : at least one candidate is requesting
//   winner     : chosen requester; on a tie, the one that is not 'last'
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port memory
// command bus. One requester owns the bus at a time; each accepted beat is
// registered onto the bus one cycle later.
//   clk, rst_n           : system clock, asynchronous active-low reset
//   req0/req1            : requester wants the bus (held for the burst)
//   wr0/wr1, addr0/addr1,
//   wdata0/wdata1        : beat contents from each requester
//   gnt0/gnt1            : registered ownership flags, never both high
//   en, wr, addr, wdata  : registered memory command bus
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  arb_state_t state, state_nxt;
  logic       last;
  logic [3:0] cnt, cnt_nxt;

  mem_cmd_t   req_cmd0, req_cmd1, beat_cmd, bus_cmd;
  logic       bus_en;
  logic       own_req;
  logic       beat;

  logic       pick_req0, pick_req1, pick_last;
  logic       pick_valid, pick_winner;

  assign req_cmd0 = {wr0, addr0, wdata0};
  assign req_cmd1 = {wr1, addr1, wdata1};

  // While a requester owns the bus, the picker only sees the other
  // requester, so its 'valid' answers "is anyone waiting to take over".
  // In IDLE it performs the normal tie-breaking arbitration.
  always_comb begin
    own_req   = 1'b0;
    pick_req0 = req0;
    pick_req1 = req1;
    pick_last = last;
    beat_cmd  = req_cmd0;
    case (state)
      OWN0: begin
        own_req   = req0;
        pick_req0 = 1'b0;
        pick_last = 1'b0;
        beat_cmd  = req_cmd0;
      end
      OWN1: begin
        own_req   = req1;
        pick_req1 = 1'b0;
        pick_last = 1'b1;
        beat_cmd  = req_cmd1;
      end
      default: ;
    endcase
  end

  rr_pick u_pick (
    .req0   (pick_req0),
    .req1   (pick_req1),
    .last   (pick_last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign beat = (state != IDLE) && own_req;

  // A release hands off or idles without taking a beat. A beat at the burst
  // limit hands off only if the other side is waiting; otherwise the owner
  // keeps the bus and the counter wraps. Any state change restarts counting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      if (pick_valid) state_nxt = pick_winner ? OWN1 : OWN0;
    end else if (!own_req) begin
      state_nxt = pick_valid ? (pick_winner ? OWN1 : OWN0) : IDLE;
    end else if (cnt == LAST_BEAT) begin
      if (pick_valid) state_nxt = pick_winner ? OWN1 : OWN0;
      cnt_nxt = 4'd0;
    end else begin
      cnt_nxt = cnt + 4'd1;
    end
    if (state_nxt != state) cnt_nxt = 4'd0;
  end

  // The pointer records the owner on entry only, so a wrap in place leaves
  // it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((state_nxt != state) && (state_nxt != IDLE))
        last <= (state_nxt == OWN1);
    end
  end

  // Address and data keep their last driven values between beats so the
  // bus does not toggle needlessly; only the strobe and write enable drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_en  <= 1'b0;
      bus_cmd <= '0;
    end else if (beat) begin
      bus_en  <= 1'b1;
      bus_cmd <= beat_cmd;
    end else begin
      bus_en     <= 1'b0;
      bus_cmd.wr <= 1'b0;
    end
  end

  assign gnt0  = (state == OWN0);
  assign gnt1  = (state == OWN1);
  assign en    = bus_en;
  assign wr    = bus_cmd.wr;
  assign addr  = bus_cmd.addr;
  assign wdata = bus_cmd.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized requester traffic, compared each cycle against a
// behavioural reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req0   = 1'b0;
  logic          req1   = 1'b0;
  logic          wr0    = 1'b0;
  logic          wr1    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, gnt1, en, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner is -1 (idle), 0 or 1; beats counts beats taken
  // during the current tenure.
  int            m_owner;
  int            m_last;
  int            m_beats;
  int            m_beat_who;
  logic          e_en, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  int remain [2];

  always #20 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .wr0    (wr0),
    .wr1    (wr1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_all();
    check_output("gnt0",  gnt0,  (m_owner == 0));
    check_output("gnt1",  gnt1,  (m_owner == 1));
    check_output("en",    en,    e_en);
    check_output("wr",    wr,    e_wr);
    check_output("addr",  addr,  e_addr);
    check_output("wdata", wdata, e_wdata);
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_last     = 1;
    m_beats    = 0;
    m_beat_who = -1;
    e_en       = 1'b0;
    e_wr       = 1'b0;
    e_addr     = '0;
    e_wdata    = '0;
  endtask

  // Predicts the outputs after the coming rising edge from the inputs
  // currently driven.
  task automatic model_step();
    bit r [2];
    int nxt, x, y;
    r[0] = req0;
    r[1] = req1;
    m_beat_who = -1;
    if (m_owner >= 0 && r[m_owner]) m_beat_who = m_owner;
    if (m_beat_who == 0) begin
      e_en = 1'b1; e_wr = wr0; e_addr = addr0; e_wdata = wdata0;
    end else if (m_beat_who == 1) begin
      e_en = 1'b1; e_wr = wr1; e_addr = addr1; e_wdata = wdata1;
    end else begin
      e_en = 1'b0; e_wr = 1'b0;
    end
    if (m_owner < 0) begin
      if (r[0] && r[1])  nxt = 1 - m_last;
      else if (r[0])     nxt = 0;
      else if (r[1])     nxt = 1;
      else               nxt = -1;
    end else begin
      x = m_owner;
      y = 1 - x;
      if (!r[x]) begin
        nxt = r[y] ? y : -1;
      end else begin
        m_beats++;
        nxt = ((m_beats % MB) == 0 && r[y]) ? y : x;
      end
    end
    if (nxt != m_owner) begin
      m_beats = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_owner = nxt;
  endtask

  // Called on a falling edge: check what the last rising edge produced,
  // drive the next inputs, predict, and move to the next falling edge.
  task automatic apply_stimulus(input logic r0, input logic w0,
                                input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic r1, input logic w1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    check_all();
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
  endtask

  task automatic drive_rand(input logic r0, input logic r1);
    apply_stimulus(r0, 1'($urandom), AW'($urandom_range(1, 2**AW - 1)), DW'($urandom),
                   r1, 1'($urandom), AW'($urandom_range(1, 2**AW - 1)), DW'($urandom));
  endtask

  initial begin
    model_reset();
    remain[0] = 0;
    remain[1] = 0;
    @(negedge clk);

    // Reset held with req0 asserted, then release.
    rst_n = 1'b0;
    repeat (3) apply_stimulus(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);

    // Single four-beat burst from requester 0.
    apply_stimulus(1'b1, 1'b1, 6'd12, 8'hA1, 1'b0, 1'b0, 6'd0, 8'h00);
    apply_stimulus(1'b1, 1'b1, 6'd14, 8'hB2, 1'b0, 1'b0, 6'd0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 6'd23, 8'hC3, 1'b0, 1'b0, 6'd0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 6'd48, 8'hD4, 1'b0, 1'b0, 6'd0, 8'h00);
    repeat (3) drive_rand(1'b0, 1'b0);

    // Contention: both requesters held together.
    repeat (25) drive_rand(1'b1, 1'b1);
    repeat (2) drive_rand(1'b0, 1'b0);

    // Burst wrap, then requester 1 joins at beat 6.
    repeat (6) drive_rand(1'b1, 1'b0);
    repeat (3) drive_rand(1'b1, 1'b1);
    repeat (3) drive_rand(1'b0, 1'b1);
    repeat (2) drive_rand(1'b0, 1'b0);

    // Early release after two beats with requester 1 pending.
    drive_rand(1'b1, 1'b0);
    repeat (2) drive_rand(1'b1, 1'b1);
    repeat (4) drive_rand(1'b0, 1'b1);

    // Asynchronous reset in the middle of an OWN1 burst.
    @(posedge clk);
    #5;
    check_all();
    rst_n = 1'b0;
    #1;
    check_output("async_en",    en,    32'd0);
    check_output("async_gnt1",  gnt1,  32'd0);
    check_output("async_gnt0",  gnt0,  32'd0);
    check_output("async_addr",  addr,  32'd0);
    check_output("async_wdata", wdata, 32'd0);
    model_reset();
    @(negedge clk);
    drive_rand(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (3) drive_rand(1'b1, 1'b1);
    repeat (2) drive_rand(1'b0, 1'b0);

    // Randomized requester traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (remain[i] == 0 && $urandom_range(0, 2) == 0)
          remain[i] = int'($urandom_range(1, 10));
      drive_rand(remain[0] > 0, remain[1] > 0);
      if (m_beat_who >= 0) remain[m_beat_who]--;
    end
    drive_rand(1'b0, 1'b0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
